// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants, next-PC select encoding and IF/ID bundle
//               type for the 5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        SEL_PC4    = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_HOLD   = 2'd3
    } next_pc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] calc_pc4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic ifid_t ifid_bubble(input logic [31:0] nop);
        ifid_t b;
        b.instr = nop;
        b.pc4   = 32'd0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with flush (bubble insert) and hold.
//               Flush takes priority over hold.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_flush,
    input  logic                i_hold,
    input  pipeline_pkg::ifid_t i_load,
    output pipeline_pkg::ifid_t o_ifid
);
    import pipeline_pkg::*;

    ifid_t r_ifid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid <= ifid_bubble(NOP_INSTR);
        end else if (i_flush) begin
            r_ifid <= ifid_bubble(NOP_INSTR);
        end else if (!i_hold) begin
            r_ifid <= i_load;
        end
    end

    assign o_ifid = r_ifid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage: PC register, next-PC selection
//               (branch > jump > stall > pc+4) and IF/ID capture.
//               Optional macro IF_FETCH_PERF_CNT_EN adds fetch/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall_if,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] pc_out
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);
    import pipeline_pkg::*;

    logic [31:0]  r_pc;
    logic [31:0]  w_pc4;
    logic [31:0]  w_next_pc;
    logic         w_flush;
    next_pc_sel_e w_sel;
    ifid_t        w_fetch;
    ifid_t        w_ifid;

    assign w_pc4   = calc_pc4(r_pc);
    assign w_flush = ex_branch_taken | id_jump;

    // The EX branch belongs to an older instruction, so it beats the ID jump.
    always_comb begin
        w_sel = SEL_PC4;
        if (ex_branch_taken) begin
            w_sel = SEL_BRANCH;
        end else if (id_jump) begin
            w_sel = SEL_JUMP;
        end else if (stall_if) begin
            w_sel = SEL_HOLD;
        end
    end

    always_comb begin
        w_next_pc = w_pc4;
        case (w_sel)
            SEL_BRANCH: w_next_pc = ex_branch_target;
            SEL_JUMP:   w_next_pc = id_jump_target;
            SEL_HOLD:   w_next_pc = r_pc;
            default:    w_next_pc = w_pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign imem_addr = r_pc;
    assign pc_out    = r_pc;

    assign w_fetch.instr = imem_instr;
    assign w_fetch.pc4   = w_pc4;
    assign w_fetch.valid = 1'b1;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_flush),
        .i_hold  (stall_if),
        .i_load  (w_fetch),
        .o_ifid  (w_ifid)
    );

    assign ifid_instr = w_ifid.instr;
    assign ifid_pc4   = w_ifid.pc4;
    assign ifid_valid = w_ifid.valid;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_flush || stall_if) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end else begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed scoreboard bench for if_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall_if;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] pc_out;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    // Bench-side model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fcnt;
    logic [31:0] m_bcnt;

    always #5 clk = ~clk;

    // Instruction ROM stand-in: 0x2008_0000 tagged with the low address bits.
    function automatic logic [31:0] imem_model(input logic [31:0] a);
        return 32'h2008_0000 | {20'd0, a[11:0]};
    endfunction

    assign imem_instr = imem_model(imem_addr);

    if_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_instr       (imem_instr),
        .stall_if         (stall_if),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .ifid_instr       (ifid_instr),
        .ifid_pc4         (ifid_pc4),
        .ifid_valid       (ifid_valid),
        .pc_out           (pc_out)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .fetch_cnt        (fetch_cnt),
        .bubble_cnt       (bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, push the expectation,
    // then pop and compare just after the rising edge.
    task automatic step(input string tag, input logic rs, input logic st,
                        input logic jp, input logic [31:0] jt,
                        input logic br, input logic [31:0] bt);
        exp_t  e;
        string t;
        @(negedge clk);
        reset            = rs;
        stall_if         = st;
        id_jump          = jp;
        id_jump_target   = jt;
        ex_branch_taken  = br;
        ex_branch_target = bt;
        if (rs) begin
            m_pc = 32'h0040_0000; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            m_fcnt = 32'd0; m_bcnt = 32'd0;
        end else if (br || jp) begin
            m_pc = br ? bt : jt;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            m_bcnt = m_bcnt + 32'd1;
        end else if (st) begin
            m_bcnt = m_bcnt + 32'd1;
        end else begin
            m_instr = imem_model(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fcnt  = m_fcnt + 32'd1;
        end
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, fcnt: m_fcnt, bcnt: m_bcnt};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".pc_out"},    pc_out,             e.pc);
            chk({t, ".imem_addr"}, imem_addr,          e.pc);
            chk({t, ".instr"},     ifid_instr,         e.instr);
            chk({t, ".pc4"},       ifid_pc4,           e.pc4);
            chk({t, ".valid"},     {31'd0, ifid_valid}, {31'd0, e.valid});
`ifdef IF_FETCH_PERF_CNT_EN
            chk({t, ".fetch_cnt"},  fetch_cnt,  e.fcnt);
            chk({t, ".bubble_cnt"}, bubble_cnt, e.bcnt);
`endif
        end
    endtask

    initial begin
        reset = 1'b1; stall_if = 1'b0; id_jump = 1'b0; id_jump_target = 32'd0;
        ex_branch_taken = 1'b0; ex_branch_target = 32'd0;
        m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        m_fcnt = 32'd0; m_bcnt = 32'd0;

        step("reset0", 1, 0, 0, 32'd0, 0, 32'd0);
        step("reset1", 1, 0, 0, 32'd0, 0, 32'd0);
        chk("reset.addr",  imem_addr, 32'h0040_0000);
        chk("reset.valid", {31'd0, ifid_valid}, 32'd0);

        step("first", 0, 0, 0, 32'd0, 0, 32'd0);
        chk("first.pc",    pc_out,     32'h0040_0004);
        chk("first.instr", ifid_instr, 32'h2008_0000);
        chk("first.pc4",   ifid_pc4,   32'h0040_0004);

        for (int i = 0; i < 3; i++) step("run", 0, 0, 0, 32'd0, 0, 32'd0);
        chk("run.pc", pc_out, 32'h0040_0010);

        step("stall0", 0, 1, 0, 32'd0, 0, 32'd0);
        step("stall1", 0, 1, 0, 32'd0, 0, 32'd0);
        chk("stall.pc",    pc_out,     32'h0040_0010);
        chk("stall.instr", ifid_instr, 32'h2008_000C);
        chk("stall.pc4",   ifid_pc4,   32'h0040_0010);
        step("resume", 0, 0, 0, 32'd0, 0, 32'd0);
        chk("resume.pc", pc_out, 32'h0040_0014);

        step("jump_self", 0, 0, 1, 32'h0040_0014, 0, 32'd0);
        chk("jump.pc",    pc_out,     32'h0040_0014);
        chk("jump.instr", ifid_instr, 32'h0000_0000);
        step("after_jump", 0, 0, 0, 32'd0, 0, 32'd0);

        step("br_jp_st", 0, 1, 1, 32'h0040_0014, 1, 32'h0040_0028);
        chk("prio.pc",    pc_out, 32'h0040_0028);
        chk("prio.valid", {31'd0, ifid_valid}, 32'd0);
        step("after_br", 0, 0, 0, 32'd0, 0, 32'd0);

        step("stall_jump", 0, 1, 1, 32'h0040_0033, 0, 32'd0);
        chk("unaligned.pc", pc_out, 32'h0040_0033);
        step("after_unal", 0, 0, 0, 32'd0, 0, 32'd0);

        step("jump_top", 0, 0, 1, 32'hFFFF_FFFC, 0, 32'd0);
        step("wrap", 0, 0, 0, 32'd0, 0, 32'd0);
        chk("wrap.pc",  pc_out,   32'h0000_0000);
        chk("wrap.pc4", ifid_pc4, 32'h0000_0000);
        step("post_wrap", 0, 0, 0, 32'd0, 0, 32'd0);

        step("reset_br", 1, 1, 0, 32'd0, 1, 32'h0040_0028);
        chk("rst_br.pc",    pc_out, 32'h0040_0000);
        chk("rst_br.valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        chk("rst_br.fcnt", fetch_cnt,  32'd0);
        chk("rst_br.bcnt", bubble_cnt, 32'd0);
`endif
        step("restart", 0, 0, 0, 32'd0, 0, 32'd0);
        chk("restart.instr", ifid_instr, 32'h2008_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_if_fetch_stage
`default_nettype wire
